demux_1_to_n_stream: RTL and testbench
======================================

DEMUX_1_TO_N_STREAM -- requirements
Module: demux_1_to_n_stream

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits (legal 1..64).
REQ-002 Parameter SEL_W, default 2, SHALL set the select width; the channel count SHALL be N_CH = 2**SEL_W (legal SEL_W 1..4).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1, SHALL indicate the upstream word is valid.
REQ-006 Port in_ready, output, 1, SHALL indicate the block accepts the upstream word this cycle.
REQ-007 Port in_data, input, DATA_W, SHALL carry the upstream payload.
REQ-008 Port in_sel, input, SEL_W, SHALL select the destination channel.
REQ-009 Port out_valid, output, N_CH, SHALL have bit k high when channel k holds a word.
REQ-010 Port out_ready, input, N_CH, SHALL have bit k high when the channel k consumer accepts.
REQ-011 Port out_data, output, N_CH*DATA_W, SHALL carry channel k on bits [k*DATA_W +: DATA_W].
REQ-012 Port stall_cnt, output, 16, SHALL report the stall count (see Configuration).

Function
REQ-013 Each channel SHALL own one registered slot with two states, EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-014 An input transfer SHALL occur when in_valid && in_ready are both high on a rising edge.
REQ-015 in_ready SHALL be combinational: high iff slot in_sel is EMPTY, or it is FULL with out_ready[in_sel] high in the same cycle.
REQ-016 An input transfer SHALL load in_data into slot in_sel and set it FULL on the next edge, giving one cycle of latency.
REQ-017 An output transfer on channel k SHALL occur when out_valid[k] && out_ready[k] are high; slot k SHALL then go EMPTY unless REQ-018 applies.
REQ-018 When an input and an output transfer hit the same channel in one cycle, the slot SHALL stay FULL and take the new word; no word SHALL be lost or duplicated.
REQ-019 Output transfers on channels other than in_sel SHALL proceed independently in the same cycle as an input transfer.
REQ-020 out_data for channel k SHALL hold its last loaded value while EMPTY and SHALL change only on a load.
REQ-021 in_sel and in_data SHALL be ignored when in_valid is low.
REQ-022 in_ready SHALL NOT depend on in_valid.

Reset
REQ-023 While rst is high, every slot SHALL be EMPTY, out_valid SHALL be all zero, out_data SHALL be all zero, and stall_cnt SHALL be zero on the following edge.
REQ-024 Reset asserted mid-operation SHALL discard all held words, with no output transfer reported for that cycle.
REQ-025 in_ready SHALL be low while rst is high.

Configuration
REQ-026 With macro DEMUX_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 every cycle where in_valid=1, in_ready=0 and rst=0, and SHALL saturate at 16'hFFFF.
REQ-027 Without DEMUX_STALL_CNT_EN, stall_cnt SHALL be the constant 16'h0000 and no counter logic SHALL be synthesised.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Reset, then in_sel=2, in_data=8'hA5, one valid cycle, all out_ready=0 -> next cycle out_valid=4'b0100, channel 2 data 8'hA5, others 0.
- Channel 1 FULL with out_ready[1]=0, send in_sel=1 -> in_ready=0, channel 1 data unchanged; send in_sel=3 the same cycle -> in_ready=1, loads.
- Channel 0 FULL with out_ready[0]=1, in_sel=0, in_data=8'h3C -> in_ready=1, channel 0 stays valid with 8'h3C, exactly one output transfer counted.
- Drain all four channels with out_ready=4'hF while streaming sel 0,1,2,3 at one word per cycle -> every word appears exactly once, in order per channel.
- With DEMUX_STALL_CNT_EN, hold a blocked in_valid for 5 cycles -> stall_cnt=5; force 70000 blocked cycles -> stall_cnt=16'hFFFF; without the macro -> stall_cnt=0 throughout.
- Assert rst with 3 slots FULL -> next cycle out_valid=0, out_data=0, stall_cnt=0.

Source files
------------

// File: rtl/demux_1_to_n_stream.sv
// demux_1_to_n_stream: routes one valid/ready stream to one of 2**SEL_W registered output slots.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - upstream handshake; in_data payload, in_sel destination channel
//   out_valid/out_ready  - per-channel handshake, bit k for channel k
//   out_data             - channel k payload on [k*DATA_W +: DATA_W]
//   stall_cnt            - saturating count of blocked input cycles when DEMUX_STALL_CNT_EN
//                          is defined, constant zero otherwise
module demux_1_to_n_stream #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [SEL_W-1:0]                 in_sel,
    output logic [(1<<SEL_W)-1:0]            out_valid,
    input  logic [(1<<SEL_W)-1:0]            out_ready,
    output logic [(1<<SEL_W)*DATA_W-1:0]     out_data,
    output logic [15:0]                      stall_cnt
);
    localparam int N_CH = 1 << SEL_W;
    logic [N_CH-1:0]             r_valid;
    logic [N_CH-1:0][DATA_W-1:0] r_data;
    logic                        w_in_ready;
    logic                        w_load;
    // a full slot can still accept when its consumer drains it in the same cycle
    assign w_in_ready = !rst && (!r_valid[in_sel] || out_ready[in_sel]);
    assign w_load     = in_valid && w_in_ready;
    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign out_data   = r_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_load && in_sel == SEL_W'(k)) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end
`ifdef DEMUX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (in_valid && !w_in_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// tb_demux_1_to_n_stream: directed scoreboard bench for demux_1_to_n_stream.
module tb_demux_1_to_n_stream;
`ifdef DEMUX_STALL_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;
    logic [7:0]  sbq [4][$];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          xfers;

    demux_1_to_n_stream #(.DATA_W(8), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one cycle; scoreboard pops on output transfers before pushing the input transfer
    task automatic step(input bit v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
        xfers = 0;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    xfers++;
                    chk($sformatf("ch%0d_expected_word", k), 64'(sbq[k].size() != 0), 64'd1);
                    if (sbq[k].size() != 0)
                        chk($sformatf("ch%0d_data", k), 64'(out_data[k*8 +: 8]), 64'(sbq[k].pop_front()));
                end
            end
            if (in_valid && in_ready) sbq[in_sel].push_back(in_data);
        end else begin
            for (int k = 0; k < 4; k++) sbq[k].delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
        @(negedge clk);
        chk("ready_in_reset", 64'(in_ready), 64'd0);
        step(1'b1, 2'd0, 8'h00, 4'h0);
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);

        // single word to channel 2
        step(1'b1, 2'd2, 8'hA5, 4'h0);
        chk("s1_valid", 64'(out_valid), 64'b0100);
        chk("s1_data", 64'(out_data), 64'h00A5_0000);

        // blocked channel 1, then channel 3 proceeds
        step(1'b1, 2'd1, 8'h11, 4'h0);
        step(1'b1, 2'd1, 8'h22, 4'h0);
        chk("s2_blocked_ready", 64'(in_ready), 64'd0);
        chk("s2_ch1_hold", 64'(out_data[15:8]), 64'h11);
        in_valid = 1'b0; #1;
        chk("ready_ignores_valid", 64'(in_ready), 64'd0);
        step(1'b1, 2'd3, 8'h33, 4'h0);
        chk("s2_ch3_valid", 64'(out_valid), 64'b1110);
        chk("s2_ch3_data", 64'(out_data[31:24]), 64'h33);

        // simultaneous drain and load on channel 0
        step(1'b1, 2'd0, 8'h5A, 4'h0);
        in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001; #1;
        chk("s3_ready", 64'(in_ready), 64'd1);
        step(1'b1, 2'd0, 8'h3C, 4'b0001);
        chk("s3_xfers", 64'(xfers), 64'd1);
        chk("s3_valid", 64'(out_valid), 64'b1111);
        chk("s3_data", 64'(out_data[7:0]), 64'h3C);

        // streaming with all consumers ready
        for (int i = 0; i < 12; i++) step(1'b1, 2'(i % 4), 8'(8'h80 + i), 4'hF);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        step(1'b0, 2'd0, 8'h00, 4'hF);
        chk("s4_drained", 64'(out_valid), 64'd0);
        chk("s4_sb_empty", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 64'd0);
        chk("s4_last_hold", 64'(out_data), 64'h8B8A_8988);

        // reset with three full slots
        step(1'b1, 2'd0, 8'h40, 4'h0);
        step(1'b1, 2'd1, 8'h41, 4'h0);
        step(1'b1, 2'd2, 8'h42, 4'h0);
        step(1'b1, 2'd0, 8'h43, 4'h0);
        chk("s6_full", 64'(out_valid), 64'b0111);
        rst = 1'b1;
        step(1'b0, 2'd0, 8'h00, 4'hF);
        rst = 1'b0;
        chk("s6_valid", 64'(out_valid), 64'd0);
        chk("s6_data", 64'(out_data), 64'd0);
        chk("s6_stall", 64'(stall_cnt), 64'd0);

        // stall counter
        step(1'b1, 2'd0, 8'h55, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 8'h66, 4'h0);
        chk("s5_stall5", 64'(stall_cnt), EN ? 64'd5 : 64'd0);
        chk("s5_ch0_hold", 64'(out_data[7:0]), 64'h55);
        in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        @(negedge clk);
        chk("s5_stall_sat", 64'(stall_cnt), EN ? 64'hFFFF : 64'd0);
        step(1'b1, 2'd0, 8'h66, 4'h0);
        chk("s5_stall_hold", 64'(stall_cnt), EN ? 64'hFFFF : 64'd0);
        chk("s5_valid", 64'(out_valid), 64'b0001);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end
endmodule
